// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter unit: next-PC select, boot/run/halt FSM, fetch counter, misalign flag
module pc_sequencer #(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int              CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              halt_i,
    input  logic              resume_i,
    input  logic              br_take_i,
    input  logic [15:0]       br_off_i,
    input  logic              jmp_i,
    input  logic [25:0]       jmp_tgt_i,
    input  logic              jr_i,
    input  logic [ADDR_W-1:0] jr_addr_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              fetch_vld_o,
    output logic              halted_o,
    output logic              misalign_o,
    output logic [CNT_W-1:0]  fetch_cnt_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] br_off_ext;
    logic [CNT_W-1:0]  cnt;
    logic              mis;
    logic              advance;

    assign pc_plus4_o  = pc + ADDR_W'(4);
    assign br_off_ext  = {{(ADDR_W-18){br_off_i[15]}}, br_off_i, 2'b00};
    assign pc_o        = pc;
    assign fetch_cnt_o = cnt;
    assign misalign_o  = mis;
    assign halted_o    = (state == ST_HALT);

    always_comb begin
        state_nxt   = state;
        fetch_vld_o = 1'b0;
        advance     = 1'b0;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN: begin
                fetch_vld_o = ~stall_i;
                advance     = ~stall_i & ~halt_i;
                if (~stall_i && halt_i)
                    state_nxt = ST_HALT;
            end
            ST_HALT: begin
                // The resume edge only restarts fetch; PC moves on the following edge.
                if (resume_i)
                    state_nxt = ST_RUN;
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    always_comb begin
        pc_nxt = pc_plus4_o;
        if (jr_i)
            pc_nxt = {jr_addr_i[ADDR_W-1:2], 2'b00};
        else if (jmp_i)
            pc_nxt = {pc_plus4_o[ADDR_W-1:28], jmp_tgt_i, 2'b00};
        else if (br_take_i)
            pc_nxt = pc_plus4_o + br_off_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
            pc    <= RESET_VEC;
            cnt   <= '0;
            mis   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (advance) begin
                pc  <= pc_nxt;
                cnt <= cnt + CNT_W'(1);
                if (jr_i && (jr_addr_i[1:0] != 2'b00))
                    mis <= 1'b1;
            end
        end
    end

endmodule
